// File: rtl/bus_master_pkg.sv
// bus_master_pkg: op codes, FSM states and bus constants shared by the bus master
package bus_master_pkg;
    localparam int WORD = 16;
    localparam logic [WORD-1:0] NULL_ADDR_DEF = '0;
    typedef enum logic [1:0] {
        OP_MOVE      = 2'd0,
        OP_READ      = 2'd1,
        OP_WRITE_IMM = 2'd2,
        OP_NOP       = 2'd3
    } op_e;
    typedef enum logic [2:0] {
        IDLE, RD_SETUP, RD_STB, RD_CAP, WR_SETUP, WR_STB, WR_REL, DONE
    } state_e;
endpackage

// File: rtl/bus_master_strobe_timer.sv
// bus_master_strobe_timer: loadable down-counter that flags when a strobe has lasted long enough
module bus_master_strobe_timer #(
    parameter int STROBE_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(STROBE_CYCLES + 1);
    localparam logic [CW-1:0] START = CW'(STROBE_CYCLES - 1);
    logic [CW-1:0] count;
    // load the strobe length ahead of a strobe state, then count down and hold at zero
    always_ff @(posedge clk or negedge reset)
        if (!reset) count <= '0;
        else if (load) count <= START;
        else if (en && count != '0) count <= count - 1'b1;
    assign expired = count == '0;
endmodule

// File: rtl/bus_master.sv
// bus_master: sequences read/write strobes and addresses so bus slaves perform move, read or immediate write
module bus_master
    import bus_master_pkg::*;
#(
    parameter int              WIDTH         = WORD,
    parameter logic [WIDTH-1:0] NULL_ADDR    = WIDTH'(NULL_ADDR_DEF),
    parameter int              STROBE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_addr,
    input  logic [WIDTH-1:0] dst_addr,
    input  logic [WIDTH-1:0] imm_data,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] rdata,
    output logic             read_clk,
    output logic             write_clk,
    output logic [WIDTH-1:0] read_bus,
    output logic [WIDTH-1:0] write_bus,
    inout  wire  [WIDTH-1:0] data_bus
);
    state_e           state, state_n;
    op_e              op_q, op_c;
    logic [WIDTH-1:0] src_q, dst_q, imm_q, src_c, dst_c;
    logic             drive_en, expired, wr_phase;

    bus_master_strobe_timer #(.STROBE_CYCLES(STROBE_CYCLES)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (state == RD_SETUP || state == WR_SETUP),
        .en      (state == RD_STB || state == WR_STB),
        .expired (expired)
    );

    // the master only owns the data bus while presenting an immediate value
    assign data_bus = drive_en ? imm_q : 'z;

    // next-state decode; the transfer context comes straight from the inputs on the accept cycle
    always_comb begin
        state_n = state;
        op_c    = state == IDLE ? op_e'(op) : op_q;
        src_c   = state == IDLE ? src_addr : src_q;
        dst_c   = state == IDLE ? dst_addr : dst_q;
        case (state)
            IDLE:     if (req) state_n = op_c == OP_NOP ? DONE : op_c == OP_WRITE_IMM ? WR_SETUP : RD_SETUP;
            RD_SETUP: state_n = RD_STB;
            RD_STB:   if (expired) state_n = RD_CAP;
            RD_CAP:   state_n = WR_SETUP;
            WR_SETUP: state_n = WR_STB;
            WR_STB:   if (expired) state_n = WR_REL;
            WR_REL:   state_n = DONE;
            default:  state_n = IDLE;
        endcase
        wr_phase = state_n inside {WR_SETUP, WR_STB};
    end

    // state, latched request and glitch-free registered bus outputs aligned with the state
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state     <= IDLE;
            op_q      <= OP_NOP;
            src_q     <= NULL_ADDR;
            dst_q     <= NULL_ADDR;
            imm_q     <= '0;
            rdata     <= '0;
            ready     <= 1'b1;
            done      <= 1'b0;
            read_clk  <= 1'b0;
            write_clk <= 1'b0;
            read_bus  <= NULL_ADDR;
            write_bus <= NULL_ADDR;
            drive_en  <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && req) begin
                op_q  <= op_e'(op);
                src_q <= src_addr;
                dst_q <= dst_addr;
                imm_q <= imm_data;
            end
            if (state == RD_CAP) rdata <= data_bus;
            ready     <= state_n == IDLE;
            done      <= state_n == DONE;
            read_clk  <= state_n == RD_STB;
            write_clk <= state_n == WR_STB;
            read_bus  <= (state_n inside {RD_SETUP, RD_STB, RD_CAP} || (wr_phase && op_c != OP_WRITE_IMM)) ? src_c : NULL_ADDR;
            write_bus <= (wr_phase && op_c != OP_READ) ? dst_c : NULL_ADDR;
            drive_en  <= wr_phase && op_c == OP_WRITE_IMM;
        end
endmodule

// File: tb/tb_bus_master.sv
// tb_bus_master: directed table-driven checks of bus_master against a behavioural 16-word slave
module tb_bus_master;
    import bus_master_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] src, dst, imm;
        int          lat, rd_n, wr_n;
        logic [15:0] wr_addr, rdata, chk_addr, chk_val;
    } vec_t;

    logic        clk = 0, reset = 0, req = 0, req3 = 0;
    logic [1:0]  op = 0, op3 = 0;
    logic [15:0] src = 0, dst = 0, imm = 0, src3 = 0, dst3 = 0, imm3 = 0;
    logic        ready, done, read_clk, write_clk;
    logic [15:0] rdata, read_bus, write_bus;
    logic        ready3, done3, read_clk3, write_clk3;
    logic [15:0] rdata3, read_bus3, write_bus3;
    wire  [15:0] data_bus, data_bus3;

    logic        s_oe = 0, s3_oe = 0, probe = 0;
    logic [15:0] s_q = 0, last_wr = 0;
    int          rd_cnt = 0, wr_cnt = 0;
    logic [15:0] mem [16] = '{16'hBEEF, 16'h1111, 16'h1234, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777,
                              16'h8888, 16'h9999, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE, 16'hFFFF};

    int          compared = 0, mismatched = 0;
    int          lat, rd0, wr0, first, second, ndone, rh, wh;
    logic [15:0] rb_s [1:40], wb_s [1:40], db_s [1:40];
    vec_t        v [6];

    always #5 clk = ~clk;

    assign data_bus  = s_oe  ? s_q      : 'z;
    assign data_bus  = probe ? 16'h5A3C : 'z;
    assign data_bus3 = s3_oe ? 16'h7777 : 'z;

    bus_master dut (
        .clk(clk), .reset(reset), .req(req), .op(op), .src_addr(src), .dst_addr(dst), .imm_data(imm),
        .ready(ready), .done(done), .rdata(rdata), .read_clk(read_clk), .write_clk(write_clk),
        .read_bus(read_bus), .write_bus(write_bus), .data_bus(data_bus)
    );

    bus_master #(.STROBE_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .req(req3), .op(op3), .src_addr(src3), .dst_addr(dst3), .imm_data(imm3),
        .ready(ready3), .done(done3), .rdata(rdata3), .read_clk(read_clk3), .write_clk(write_clk3),
        .read_bus(read_bus3), .write_bus(write_bus3), .data_bus(data_bus3)
    );

    // slave drives from a read strobe until the next falling write strobe, like ram
    always @(posedge read_clk or negedge write_clk or negedge reset)
        if (!reset) s_oe <= 1'b0;
        else if (read_clk) begin
            s_oe   <= read_bus[15:4] == 12'h010;
            s_q    <= mem[read_bus[3:0]];
            rd_cnt <= rd_cnt + 1;
        end else s_oe <= 1'b0;

    // slave write on the rising write strobe
    always @(posedge write_clk) begin
        wr_cnt  <= wr_cnt + 1;
        last_wr <= write_bus;
        if (write_bus[15:4] == 12'h010) mem[write_bus[3:0]] <= data_bus;
    end

    // second slave for the long-strobe instance
    always @(posedge read_clk3 or negedge write_clk3 or negedge reset)
        if (!reset) s3_oe <= 1'b0;
        else s3_oe <= read_clk3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic [1:0] o, input logic [15:0] s, input logic [15:0] d, input logic [15:0] i,
                        output int l);
        @(negedge clk);
        op = o; src = s; dst = d; imm = i; req = 1;
        @(posedge clk);
        #1 req = 0;
        l = 0;
        for (int n = 1; n <= 40 && l == 0; n++) begin
            @(negedge clk);
            rb_s[n] = read_bus;
            wb_s[n] = write_bus;
            db_s[n] = data_bus;
            if (done) l = n;
        end
    endtask

    initial begin
        v[0] = '{OP_MOVE,      16'h0100, 16'h0105, 16'h0000, 7, 1, 1, 16'h0105, 16'hBEEF, 16'h0105, 16'hBEEF};
        v[1] = '{OP_READ,      16'h0102, 16'h0000, 16'h0000, 7, 1, 1, 16'h0000, 16'h1234, 16'h0102, 16'h1234};
        v[2] = '{OP_WRITE_IMM, 16'h0000, 16'h0103, 16'hA5A5, 4, 0, 1, 16'h0103, 16'h1234, 16'h0103, 16'hA5A5};
        v[3] = '{OP_NOP,       16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 16'h1234, 16'h0103, 16'hA5A5};
        v[4] = '{OP_MOVE,      16'h0107, 16'h0107, 16'h0000, 7, 1, 1, 16'h0107, 16'h7777, 16'h0107, 16'h7777};
        v[5] = '{OP_MOVE,      16'h0103, 16'h010F, 16'h0000, 7, 1, 1, 16'h010F, 16'hA5A5, 16'h010F, 16'hA5A5};

        #12;
        check("reset ready", ready, 1);
        check("reset done", done, 0);
        check("reset read_clk", read_clk, 0);
        check("reset write_clk", write_clk, 0);
        check("reset read_bus", read_bus, 0);
        check("reset write_bus", write_bus, 0);
        check("reset rdata", rdata, 0);
        @(negedge clk);
        reset = 1;

        for (int k = 0; k < 6; k++) begin
            rd0 = rd_cnt;
            wr0 = wr_cnt;
            xfer(v[k].op, v[k].src, v[k].dst, v[k].imm, lat);
            check($sformatf("latency v%0d", k), lat, v[k].lat);
            check($sformatf("rdata v%0d", k), rdata, v[k].rdata);
            check($sformatf("read pulses v%0d", k), rd_cnt - rd0, v[k].rd_n);
            check($sformatf("write pulses v%0d", k), wr_cnt - wr0, v[k].wr_n);
            if (v[k].wr_n > 0) check($sformatf("write addr v%0d", k), last_wr, v[k].wr_addr);
            check($sformatf("slave mem v%0d", k), mem[v[k].chk_addr[3:0]], v[k].chk_val);
            if (v[k].op != OP_NOP && v[k].lat > 3)
                check($sformatf("write_bus setup v%0d", k), wb_s[v[k].lat-3], v[k].wr_addr);
            if (v[k].op == OP_MOVE || v[k].op == OP_READ) begin
                check($sformatf("read_bus rd_setup v%0d", k), rb_s[1], v[k].src);
                check($sformatf("read_bus wr_setup v%0d", k), rb_s[4], v[k].src);
                check($sformatf("data_bus rd_cap v%0d", k), db_s[3], v[k].rdata);
            end
            if (v[k].op == OP_WRITE_IMM) begin
                check($sformatf("data_bus wr_setup v%0d", k), db_s[1], v[k].imm);
                check($sformatf("data_bus wr_stb v%0d", k), db_s[2], v[k].imm);
                check($sformatf("read_bus idle v%0d", k), rb_s[2], 0);
            end
            @(negedge clk);
            check($sformatf("ready after v%0d", k), ready, 1);
            check($sformatf("buses null v%0d", k), {read_bus, write_bus}, 0);
            probe = 1;
            #1 check($sformatf("data_bus released v%0d", k), data_bus, 16'h5A3C);
            probe = 0;
        end

        // reset during the read strobe of a MOVE
        wr0 = wr_cnt;
        @(negedge clk);
        op = OP_MOVE; src = 16'h0100; dst = 16'h0106; req = 1;
        @(posedge clk);
        #1 req = 0;
        @(negedge clk);
        @(negedge clk);
        check("abort in rd_stb", read_clk, 1);
        reset = 0;
        #1;
        check("abort read_clk", read_clk, 0);
        check("abort buses", {read_bus, write_bus}, 0);
        check("abort ready", ready, 1);
        check("abort rdata", rdata, 0);
        probe = 1;
        #1 check("abort data_bus", data_bus, 16'h5A3C);
        probe = 0;
        @(negedge clk);
        reset = 1;
        repeat (10) @(negedge clk);
        check("abort dst unchanged", mem[6], 16'h6666);
        check("abort no write", wr_cnt - wr0, 0);
        check("abort idle", ready, 1);

        // req held high: back-to-back MOVEs without double acceptance
        rd0 = rd_cnt; first = 0; second = 0; ndone = 0;
        @(negedge clk);
        op = OP_MOVE; src = 16'h0101; dst = 16'h0108; req = 1;
        @(posedge clk);
        #1;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first == 0) first = n;
                else second = n;
            end
        end
        req = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("b2b first done", first, 7);
        check("b2b second done", second, 15);
        check("b2b done count", ndone, 2);
        check("b2b read pulses", rd_cnt - rd0, 2);
        check("b2b mem", mem[8], 16'h1111);
        check("b2b idle", ready, 1);

        // three-cycle strobes
        rh = 0; wh = 0; lat = 0;
        @(negedge clk);
        op3 = OP_MOVE; src3 = 16'h0100; dst3 = 16'h0105; req3 = 1;
        @(posedge clk);
        #1 req3 = 0;
        for (int n = 1; n <= 30 && lat == 0; n++) begin
            @(negedge clk);
            if (read_clk3) rh++;
            if (write_clk3) begin
                wh++;
                check("s3 write_bus", write_bus3, 16'h0105);
            end
            if (done3) lat = n;
        end
        check("s3 read_clk width", rh, 3);
        check("s3 write_clk width", wh, 3);
        check("s3 latency", lat, 11);
        check("s3 rdata", rdata3, 16'h7777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
